spkr_tone_gen: RTL and testbench

- Speaker-side consumer of the 32-bit desired-frequency word (integer Hz) produced by the keypad/song decoder.
- Converts the word into a 50 %-duty square wave on the DE0-Nano-SoC speaker pin.
- Computes half-period = CLK_HZ / (2·f) with an iterative divider, no combinational divide.
- New pitches take effect glitch-free at a half-period boundary, so song note changes never produce runt pulses.

---
 rtl/spkr_pkg.sv | 20 ++
 rtl/spkr_udiv.sv | 57 +++++
 rtl/spkr_tone_gen.sv | 109 ++++++++++
 tb/tb_spkr_tone_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spkr_pkg.sv
// Shared types and constants for the speaker tone path and the keypad/song decoder.
package spkr_pkg;
  localparam int FREQ_W              = 32;
  localparam int CLK_HZ_DEFAULT      = 50_000_000;
  localparam int MAX_FREQ_HZ_DEFAULT = 20_000;

  typedef logic [FREQ_W-1:0] freq_t;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_WAIT} state_t;

  localparam freq_t NOTE_C4  = 32'd261;
  localparam freq_t NOTE_D4  = 32'd294;
  localparam freq_t NOTE_E4  = 32'd330;
  localparam freq_t NOTE_F4  = 32'd349;
  localparam freq_t NOTE_G4  = 32'd392;
  localparam freq_t NOTE_A4  = 32'd440;
  localparam freq_t NOTE_AS4 = 32'd466;
  localparam freq_t NOTE_B4  = 32'd494;
  localparam freq_t NOTE_C5  = 32'd523;
endpackage

// File: rtl/spkr_udiv.sv
// Sequential restoring unsigned divider: one quotient bit per clock, W clocks per divide.
module spkr_udiv #(
  parameter int W = 32
) (
  input  logic         FPGA_CLK1_50,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);
  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem, quo, dvs;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       rem_sh, diff;

  // diff[W] is the borrow: set when the shifted remainder is below the divisor
  assign rem_sh   = {rem, quo[W-1]};
  assign diff     = rem_sh - {1'b0, dvs};
  assign quotient = quo;

  always_ff @(posedge FPGA_CLK1_50 or negedge rstn) begin
    if (!rstn) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= '0;
        quo  <= dividend;
        dvs  <= divisor;
        cnt  <= CNT_W'(W);
        busy <= 1'b1;
      end else if (busy) begin
        if (!diff[W]) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= rem_sh[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/spkr_tone_gen.sv
// Square-wave speaker driver: frequency word -> half-period via iterative divide,
// new pitches applied only at level boundaries so no runt pulses reach the speaker.
module spkr_tone_gen
  import spkr_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int MAX_FREQ_HZ = MAX_FREQ_HZ_DEFAULT,
  parameter int W           = FREQ_W
) (
  input  logic         FPGA_CLK1_50,
  input  logic         rstn,
  input  logic [W-1:0] desired_frequency,
  input  logic         enable,
  output logic         spkr,
  output logic         tone_active,
  output logic         div_busy,
  output logic [W-1:0] half_period
);
  localparam logic [W-1:0] CLK_W = W'(CLK_HZ);
  localparam logic [W-1:0] MAX_W = W'(MAX_FREQ_HZ);

  state_t       state, state_nx;
  logic [W-1:0] f_eff, f_lat, cnt, pending, quotient;
  logic         pending_valid;
  logic         div_start, div_done, at_bound, do_mute, do_load;

  assign f_eff       = (desired_frequency > MAX_W) ? MAX_W : desired_frequency;
  assign at_bound    = (half_period != '0) && (cnt == half_period - 1'b1);
  assign tone_active = enable && (half_period != '0);

  spkr_udiv #(.W(W)) u_div (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .rstn         (rstn),
    .start        (div_start),
    .dividend     (CLK_W),
    .divisor      ({f_eff[W-2:0], 1'b0}),
    .busy         (div_busy),
    .done         (div_done),
    .quotient     (quotient)
  );

  always_ff @(posedge FPGA_CLK1_50 or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (f_eff != f_lat && f_eff != '0) state_nx = S_DIV;
      S_DIV:   if (div_done) state_nx = S_WAIT;
      S_WAIT:  if (do_load) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // While disabled there is no boundary to wait for, so a pending pitch loads at once
  always_comb begin
    div_start = 1'b0;
    do_mute   = 1'b0;
    do_load   = 1'b0;
    case (state)
      S_IDLE: if (f_eff != f_lat) begin
        if (f_eff == '0) do_mute   = 1'b1;
        else             div_start = 1'b1;
      end
      S_WAIT:  do_load = pending_valid && (half_period == '0 || !enable || at_bound);
      default: ;
    endcase
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge rstn) begin
    if (!rstn) begin
      f_lat         <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      half_period   <= '0;
      cnt           <= '0;
      spkr          <= 1'b0;
    end else begin
      if (div_start) f_lat <= f_eff;
      if (state == S_DIV && div_done) begin
        pending       <= quotient;
        pending_valid <= 1'b1;
      end
      if (do_mute) begin
        f_lat       <= '0;
        half_period <= '0;
        cnt         <= '0;
        spkr        <= 1'b0;
      end else begin
        // On a boundary load the toggle still happens; the new value times the next level
        if (do_load) begin
          half_period   <= pending;
          pending_valid <= 1'b0;
        end
        if (!enable || half_period == '0) begin
          cnt  <= '0;
          spkr <= 1'b0;
        end else if (at_bound) begin
          cnt  <= '0;
          spkr <= ~spkr;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spkr_tone_gen.sv
// Directed bench for spkr_tone_gen, run at CLK_HZ = 1 MHz so whole tone levels fit the cycle budget.
module tb_spkr_tone_gen;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] freq;
  logic        en;
  logic        spkr, tone_active, div_busy;
  logic [31:0] half_period;

  int n_pass = 0;
  int n_tot  = 0;

  always #10 clk = ~clk;

  spkr_tone_gen #(.CLK_HZ(1_000_000), .MAX_FREQ_HZ(20_000), .W(32)) dut (
    .FPGA_CLK1_50      (clk),
    .rstn              (rstn),
    .desired_frequency (freq),
    .enable            (en),
    .spkr              (spkr),
    .tone_active       (tone_active),
    .div_busy          (div_busy),
    .half_period       (half_period)
  );

  typedef struct {
    logic [31:0] f;
    logic        en;
    logic [31:0] hp;
    logic        ta;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_edge();
    logic s;
    int   t;
    s = spkr;
    t = 0;
    while (spkr === s && t < 5000) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Length of the level that started at the most recent spkr change
  task automatic count_level(output int n);
    logic s;
    s = spkr;
    n = 0;
    while (spkr === s && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int   a, b, n, pulses;
    logic pb, xseen;

    // 1 MHz clock: 1e6 / (2 f), floored
    vecs[0] = '{f: 440,   en: 1'b1, hp: 1136, ta: 1'b1};
    vecs[1] = '{f: 261,   en: 1'b1, hp: 1915, ta: 1'b1};
    vecs[2] = '{f: 30000, en: 1'b1, hp: 25,   ta: 1'b1};
    vecs[3] = '{f: 20000, en: 1'b1, hp: 25,   ta: 1'b1};
    vecs[4] = '{f: 20001, en: 1'b1, hp: 25,   ta: 1'b1};
    vecs[5] = '{f: 0,     en: 1'b1, hp: 0,    ta: 1'b0};
    vecs[6] = '{f: 349,   en: 1'b0, hp: 1432, ta: 1'b0};
    vecs[7] = '{f: 494,   en: 1'b1, hp: 1012, ta: 1'b1};

    rstn = 1'b0;
    freq = 32'd0;
    en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset spkr", spkr, 0);
    chk("reset half_period", half_period, 0);
    chk("reset div_busy", div_busy, 0);
    chk("reset tone_active", tone_active, 0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      freq = vecs[i].f;
      en   = vecs[i].en;
      repeat (2100) @(negedge clk);
      chk($sformatf("vec%0d half_period", i), half_period, vecs[i].hp);
      chk($sformatf("vec%0d tone_active", i), tone_active, vecs[i].ta);
      if (!vecs[i].en) chk($sformatf("vec%0d spkr low", i), spkr, 0);
    end

    // Mute takes effect on the very next edge
    freq = 32'd0;
    @(negedge clk);
    chk("mute half_period", half_period, 0);
    chk("mute spkr", spkr, 0);
    chk("mute tone_active", tone_active, 0);

    // Steady tone: both levels exactly one half-period
    freq = 32'd440;
    wait_edge();
    count_level(a);
    count_level(b);
    chk("steady level 1", a, 1136);
    chk("steady level 2", b, 1136);
    chk("steady tone_active", tone_active, 1);

    // Pitch change mid-level: current level completes, next one uses the new pitch
    wait_edge();
    n = 0;
    a = 0;
    pb = spkr;
    while (spkr === pb && n < 5000) begin
      @(negedge clk);
      n++;
      if (n == 300) freq = 32'd261;
    end
    chk("glitch current level", n, 1136);
    count_level(b);
    chk("glitch next level", b, 1915);

    // Rapid changes while the divider is busy: last value wins
    freq = 32'd0;
    repeat (2) @(negedge clk);
    freq   = 32'd440;
    pulses = 0;
    xseen  = 1'b0;
    pb     = div_busy;
    for (int c = 0; c < 3015; c++) begin
      @(negedge clk);
      if (c == 5)  freq = 32'd466;
      if (c == 15) freq = 32'd494;
      if ($isunknown({spkr, half_period, div_busy, tone_active})) xseen = 1'b1;
      if (div_busy && !pb) pulses++;
      pb = div_busy;
    end
    chk("rapid half_period", half_period, 1012);
    chk("rapid no X", xseen, 0);
    chk("rapid busy pulses >= 2", pulses >= 2, 1);

    // Enable gating: pitch computed while disabled, first rise one half-period after enable
    en   = 1'b0;
    freq = 32'd349;
    repeat (100) @(negedge clk);
    chk("disabled spkr", spkr, 0);
    chk("disabled half_period", half_period, 1432);
    chk("disabled tone_active", tone_active, 0);
    en = 1'b1;
    n  = 0;
    while (spkr !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("enable first rise", n, 1432);

    // Asynchronous reset mid-level, then recompute from scratch
    repeat (500) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async reset spkr", spkr, 0);
    chk("async reset half_period", half_period, 0);
    chk("async reset div_busy", div_busy, 0);
    repeat (2) @(negedge clk);
    freq = 32'd440;
    rstn = 1'b1;
    n = 0;
    while (half_period !== 32'd1136 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("post-reset half_period", half_period, 1136);
    chk("post-reset tone_active", tone_active, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
